// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: turns a length-prefixed byte stream into sequential
// 32-bit imem writes and holds the CPU in start_up until the whole program is in place.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   LEN_HI | waiting for high byte of the word count N
//   LEN_LO | waiting for low byte of N; decides empty / too long / data
//   DATA   | collecting instruction bytes, MSB first, one write per word
//   FLUSH  | last word's write strobe is on the bus, no more bytes taken
//   DONE   | program loaded, CPU released; idle until reset
//   ERR    | N exceeded MAX_WORDS; nothing written, CPU held; idle until reset
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0040_0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        start_up_n,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_start_up,
    output logic        load_done,
    output logic [15:0] word_count,
    output logic        err_len
);

    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        DATA,
        FLUSH,
        DONE,
        ERR
    } state_t;

    state_t      state;
    logic [7:0]  len_hi;
    logic [15:0] frame_len;
    logic [1:0]  byte_idx;
    logic [23:0] word_buf;

    logic        accept;
    logic [15:0] rx_len;
    logic [31:0] rx_word;
    logic        last_word;

    assign accept    = byte_valid && byte_ready;
    assign rx_len    = {len_hi, byte_data};
    assign rx_word   = {word_buf, byte_data};
    assign last_word = (word_count + 16'd1) == frame_len;

    always_ff @(posedge clk or negedge start_up_n) begin
        if (!start_up_n) begin
            state        <= LEN_HI;
            len_hi       <= 8'd0;
            frame_len    <= 16'd0;
            byte_idx     <= 2'd0;
            word_buf     <= 24'd0;
            byte_ready   <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= BASE_ADDR;
            imem_wdata   <= 32'd0;
            cpu_start_up <= 1'b1;
            load_done    <= 1'b0;
            word_count   <= 16'd0;
            err_len      <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                LEN_HI: begin
                    // ready comes up one edge after reset release, then stays up through DATA
                    byte_ready <= 1'b1;
                    if (accept) begin
                        len_hi <= byte_data;
                        state  <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        frame_len <= rx_len;
                        if (rx_len == 16'd0) begin
                            state        <= DONE;
                            byte_ready   <= 1'b0;
                            cpu_start_up <= 1'b0;
                            load_done    <= 1'b1;
                        end else if ({16'd0, rx_len} > 32'(MAX_WORDS)) begin
                            state      <= ERR;
                            byte_ready <= 1'b0;
                            err_len    <= 1'b1;
                        end else begin
                            state    <= DATA;
                            byte_idx <= 2'd0;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        byte_idx <= byte_idx + 2'd1;
                        word_buf <= rx_word[23:0];
                        if (byte_idx == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_wdata <= rx_word;
                            imem_addr  <= BASE_ADDR + {14'd0, word_count, 2'b00};
                            word_count <= word_count + 16'd1;
                            if (last_word) begin
                                state      <= FLUSH;
                                byte_ready <= 1'b0;
                            end
                        end
                    end
                end
                FLUSH: begin
                    state        <= DONE;
                    cpu_start_up <= 1'b0;
                    load_done    <= 1'b1;
                end
                DONE: begin
                    byte_ready <= 1'b0;
                end
                ERR: begin
                    byte_ready <= 1'b0;
                end
                default: begin
                    state      <= LEN_HI;
                    byte_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: random and directed frames compared cycle by cycle
// against a byte-accept-counting reference model.
module tb_imem_loader;

    localparam logic [31:0] BASE      = 32'h0040_0000;
    localparam int          MAX_WORDS = 256;

    logic        clk;
    logic        start_up_n;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_start_up;
    logic        load_done;
    logic [15:0] word_count;
    logic        err_len;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] frame[$];

    imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAX_WORDS)) dut (
        .clk          (clk),
        .start_up_n   (start_up_n),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_start_up (cpu_start_up),
        .load_done    (load_done),
        .word_count   (word_count),
        .err_len      (err_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic frame_len(input int n);
        frame.delete();
        frame.push_back(8'((n >> 8) & 255));
        frame.push_back(8'(n & 255));
    endtask

    task automatic frame_word(input logic [31:0] w);
        frame.push_back(w[31:24]);
        frame.push_back(w[23:16]);
        frame.push_back(w[15:8]);
        frame.push_back(w[7:0]);
    endtask

    task automatic frame_random(input int n);
        frame_len(n);
        for (int j = 0; j < n; j++) frame_word($urandom);
    endtask

    task automatic check_reset_values();
        check("rst_byte_ready", 32'(byte_ready), 32'd0);
        check("rst_imem_we", 32'(imem_we), 32'd0);
        check("rst_imem_addr", imem_addr, BASE);
        check("rst_imem_wdata", imem_wdata, 32'd0);
        check("rst_cpu_start_up", 32'(cpu_start_up), 32'd1);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_word_count", 32'(word_count), 32'd0);
        check("rst_err_len", 32'(err_len), 32'd0);
    endtask

    // Reset, then stream the current frame. The model only counts accepted bytes:
    // a write is due the cycle after every 4th data byte, done/err follow the final byte.
    task automatic run_frame(input int gap_pct, input int gap_pos, input int gap_len,
                             input int abort_at);
        int          n, mode, consumed, idx, s, fin, k, budget, gap_left;
        bit          gap_done, we_due, exp_rdy, exp_done, exp_err, aborted, finished;
        logic [31:0] words[$];
        logic [31:0] exp_w;

        n = {16'd0, frame[0], frame[1]};
        if (n == 0)              mode = 0;
        else if (n > MAX_WORDS)  mode = 2;
        else                     mode = 1;
        consumed = (mode == 1) ? 2 + 4 * n : 2;
        for (int j = 0; j < n && mode == 1; j++)
            words.push_back({frame[2+4*j], frame[3+4*j], frame[4+4*j], frame[5+4*j]});

        @(negedge clk);
        byte_valid = 1'b0;
        start_up_n = 1'b0;
        #1;
        check_reset_values();
        @(negedge clk);
        start_up_n = 1'b1;

        idx = 0; fin = -1; k = 0; gap_left = 0; gap_done = 0; we_due = 0;
        aborted = 0; finished = 0;
        budget = 40 + consumed * 4 + gap_len;
        s = 0;
        while (s < budget) begin
            exp_rdy  = (s >= 1) && (fin < 0 || s <= fin);
            exp_done = (mode != 2) && (fin >= 0) && (s >= fin + ((mode == 1) ? 2 : 1));
            exp_err  = (mode == 2) && (fin >= 0) && (s >= fin + 1);
            check("byte_ready", 32'(byte_ready), 32'(exp_rdy));
            check("imem_we", 32'(imem_we), 32'(we_due));
            check("load_done", 32'(load_done), 32'(exp_done));
            check("cpu_start_up", 32'(cpu_start_up), 32'(!exp_done));
            check("err_len", 32'(err_len), 32'(exp_err));
            if (imem_we) begin
                exp_w = (k < words.size()) ? words[k] : 32'hDEAD_BEEF;
                check("imem_addr", imem_addr, BASE + 32'(k) * 32'd4);
                check("imem_wdata", imem_wdata, exp_w);
                check("word_count_at_we", 32'(word_count), 32'(k + 1));
                k++;
            end
            if (abort_at >= 0 && idx == abort_at) begin
                byte_valid = 1'b0;
                start_up_n = 1'b0;
                #1;
                check("abort_imem_we", 32'(imem_we), 32'd0);
                check("abort_cpu_start_up", 32'(cpu_start_up), 32'd1);
                check("abort_byte_ready", 32'(byte_ready), 32'd0);
                check("abort_word_count", 32'(word_count), 32'd0);
                aborted = 1;
                break;
            end
            if (fin >= 0 && s >= fin + 3) begin
                finished = 1;
                break;
            end

            we_due = 0;
            if (idx < consumed) begin
                if (idx == gap_pos && !gap_done) begin
                    gap_left = gap_len;
                    gap_done = 1;
                end
                if (gap_left > 0) begin
                    byte_valid = 1'b0;
                    gap_left--;
                end else if (int'($urandom_range(99)) < gap_pct) begin
                    byte_valid = 1'b0;
                end else begin
                    byte_valid = 1'b1;
                    byte_data  = frame[idx];
                    if (byte_ready) begin
                        if (mode == 1 && idx >= 2 && ((idx - 2) % 4) == 3) we_due = 1;
                        if (idx == consumed - 1) fin = s;
                        idx++;
                    end
                end
            end else begin
                byte_valid = 1'b1;
                byte_data  = 8'($urandom);
            end
            @(negedge clk);
            s++;
        end

        byte_valid = 1'b0;
        if (!aborted) begin
            check("completed_in_budget", 32'(finished), 32'd1);
            check("final_word_count", 32'(word_count), 32'((mode == 1) ? n : 0));
            check("write_total", 32'(k), 32'((mode == 1) ? n : 0));
        end
    endtask

    initial begin
        start_up_n = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'd0;

        frame_len(1);
        frame_word(32'h2008_0004);
        run_frame(0, -1, 0, -1);

        frame_len(3);
        frame_word(32'h2008_0004);
        frame_word(32'h1100_0002);
        frame_word(32'h0000_0000);
        run_frame(0, -1, 0, -1);
        run_frame(0, 8, 5, -1);

        frame_len(0);
        run_frame(0, -1, 0, -1);

        frame_len(257);
        run_frame(0, -1, 0, -1);

        frame_random(256);
        run_frame(10, -1, 0, -1);

        frame_len(1);
        frame_word(32'hAABB_CCDD);
        run_frame(0, -1, 0, 4);
        frame_len(1);
        frame_word(32'h0123_4567);
        run_frame(0, -1, 0, -1);

        frame_len($urandom_range(65535, 257));
        run_frame(30, -1, 0, -1);

        for (int r = 0; r < 6; r++) begin
            frame_random($urandom_range(12, 1));
            run_frame($urandom_range(60, 0), $urandom_range(20, 2), $urandom_range(6, 0), -1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
